// File: rtl/demux14_buf_pkg.sv
// Shared definitions for the registered 1-to-N demultiplexer family.
package demux14_buf_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/demux14_buf_slot.sv
// One output channel: a single-entry holding register with valid/ready and
// a wrapping delivered-word counter.
module demux_slot #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data_out,
  output logic [CNT_W-1:0] count
);

  logic             valid_reg, valid_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             drain;

  assign drain = valid_reg && ready;

  always_comb begin
    valid_next = valid_reg;
    data_next  = data_reg;
    count_next = count_reg;
    if (drain) begin
      valid_next = 1'b0;
      count_next = count_reg + CNT_W'(1);
    end
    // A load on the same edge as a drain refills the slot, keeping it valid.
    if (load) begin
      valid_next = 1'b1;
      data_next  = data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      count_reg <= '0;
    end else begin
      valid_reg <= valid_next;
      data_reg  <= data_next;
      count_reg <= count_next;
    end
  end

  assign valid    = valid_reg;
  assign data_out = data_reg;
  assign count    = count_reg;

endmodule

// File: rtl/demux14_buf.sv
// Registered 1-to-4 demultiplexer: steers each accepted word into the
// holding slot chosen by in_sel; every channel drains independently.
module demux14_buf
  import demux14_buf_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [WIDTH-1:0]        in_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH*CNT_W-1:0] out_count
);

  logic [NUM_CH-1:0] sel_hot;
  logic [NUM_CH-1:0] load;

  // Readiness looks only at the addressed slot, so a stalled consumer never
  // blocks words headed elsewhere.
  assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
  assign sel_hot  = sel_onehot(in_sel);
  assign load     = (in_valid && in_ready) ? sel_hot : '0;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
      demux_slot #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
      ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .load    (load[gi]),
        .data_in (in_data),
        .ready   (out_ready[gi]),
        .valid   (out_valid[gi]),
        .data_out(out_data[gi*WIDTH +: WIDTH]),
        .count   (out_count[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate

endmodule
